// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder and the immediate extension unit.
package imm_encoder_pkg;

  // Encoding modes, same codes as the immediate extension unit
  localparam logic [1:0] IMM_ZE24 = 2'b00;
  localparam logic [1:0] IMM_SE24 = 2'b01;
  localparam logic [1:0] IMM_SE12 = 2'b10;
  localparam logic [1:0] IMM_ROT  = 2'b11;

  localparam int IMM_FIELD_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_e;

  // Representability test for the single-cycle modes (rotated mode handled elsewhere)
  function automatic logic imm_fix_fits(input logic [1:0] mode, input logic [31:0] v);
    logic f;
    f = 1'b0;
    case (mode)
      IMM_ZE24: f = ~(|v[31:24]);
      IMM_SE24: f = (&v[31:23]) | ~(|v[31:23]);
      IMM_SE12: f = (&v[31:11]) | ~(|v[31:11]);
      default:  f = 1'b0;
    endcase
    return f;
  endfunction

  // Packed field for the single-cycle modes, before masking by fits
  function automatic logic [IMM_FIELD_W-1:0] imm_fix_field(input logic [1:0] mode,
                                                           input logic [31:0] v);
    logic [IMM_FIELD_W-1:0] f;
    f = '0;
    case (mode)
      IMM_ZE24, IMM_SE24: f = v[23:0];
      IMM_SE12:           f = {12'b0, v[11:0]};
      default:            f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_encoder_rot_check.sv
// Combinational test of one rotated-immediate candidate: rotl(v, 2r) must fit in 8 bits.
module imm_rot_check (
  input  logic [31:0] v,
  input  logic [3:0]  r,
  output logic        match,
  output logic [7:0]  imm8
);

  logic [63:0] dbl;
  logic [31:0] rot;

  // Upper half of {v,v} shifted left by 2r is rotl(v, 2r), valid for a zero shift too
  always_comb begin
    dbl   = {v, v} << {r, 1'b0};
    rot   = dbl[63:32];
    match = ~(|rot[31:8]);
    imm8  = rot[7:0];
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: checks whether a 32-bit value fits an instruction immediate field
// and packs it. Rotated mode searches one rotation amount per cycle.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ROT_STEPS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            data_i,
  input  logic [1:0]             mode_i,
  output logic                   ready,
  output logic                   done,
  output logic                   fits,
  output logic [IMM_FIELD_W-1:0] imm_o
);

  // Rotation field in the packed immediate is 4 bits wide
  localparam logic [3:0] R_LAST = 4'(ROT_STEPS - 1);

  enc_state_e             state_q, state_d;
  logic [31:0]            data_q, data_d;
  logic [1:0]             mode_q, mode_d;
  logic [3:0]             r_q, r_d;
  logic                   fits_q, fits_d;
  logic [IMM_FIELD_W-1:0] imm_q, imm_d;

  logic                   rot_match;
  logic [7:0]             rot_imm8;
  logic                   fix_fits;
  logic [IMM_FIELD_W-1:0] fix_field;

  imm_rot_check u_rot (
    .v     (data_q),
    .r     (r_q),
    .match (rot_match),
    .imm8  (rot_imm8)
  );

  // Single-cycle mode evaluation on the latched operand
  always_comb begin
    fix_fits  = imm_fix_fits(mode_q, data_q);
    fix_field = imm_fix_field(mode_q, data_q);
  end

  // Next-state and result loading
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    r_d     = r_q;
    fits_d  = fits_q;
    imm_d   = imm_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = data_i;
          mode_d  = mode_i;
          r_d     = 4'd0;
          state_d = (mode_i == IMM_ROT) ? ST_SEARCH : ST_CHECK;
        end
      end
      ST_CHECK: begin
        fits_d  = fix_fits;
        imm_d   = fix_fits ? fix_field : '0;
        state_d = ST_DONE;
      end
      ST_SEARCH: begin
        if (rot_match) begin
          // first hit is the smallest r, so the encoding is unique
          fits_d  = 1'b1;
          imm_d   = {12'b0, r_q, rot_imm8};
          state_d = ST_DONE;
        end else if (r_q == R_LAST) begin
          fits_d  = 1'b0;
          imm_d   = '0;
          state_d = ST_DONE;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      mode_q  <= IMM_ZE24;
      r_q     <= 4'd0;
      fits_q  <= 1'b0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      fits_q  <= fits_d;
      imm_q   <= imm_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign fits  = fits_q;
  assign imm_o = imm_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and random checks for imm_encoder.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data_i;
  logic [1:0]  mode_i;
  logic        ready, done, fits;
  logic [23:0] imm_o;

  int n_chk = 0;
  int n_err = 0;

  imm_encoder #(.ROT_STEPS(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data_i (data_i),
    .mode_i (mode_i),
    .ready  (ready),
    .done   (done),
    .fits   (fits),
    .imm_o  (imm_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Extension unit model, used for round-trip checks
  function automatic logic [31:0] extend(input logic [1:0] m, input logic [23:0] f);
    case (m)
      2'b00:   return {8'b0, f};
      2'b01:   return {{8{f[23]}}, f};
      2'b10:   return {{20{f[11]}}, f[11:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Entered at posedge+1; returns at posedge+1 of the cycle where done is high.
  // lat = number of edges after the accepting edge, 0 on timeout.
  task automatic do_enc(input logic [1:0] m, input logic [31:0] v, input bit poke,
                        output int lat, output logic f, output logic [23:0] im);
    lat = 0;
    start = 1'b1; data_i = v; mode_i = m;
    @(posedge clk); #1;
    start = 1'b0; data_i = ~v; mode_i = ~m;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (poke && n == 1) begin
        start = 1'b1; data_i = 32'h000000FF; mode_i = 2'b00;
      end
    end
    start = 1'b0;
    f = fits; im = imm_o;
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [31:0] v;
    logic        f;
    logic [23:0] im;
    int          lat;
  } vec_t;

  vec_t vt[15];

  initial begin
    int          lat;
    logic        f;
    logic [23:0] im;
    logic [31:0] v, x;
    logic [1:0]  m;
    logic        rf;
    int          s;

    vt[0]  = '{2'b00, 32'h00ABCDEF, 1'b1, 24'hABCDEF, 1};
    vt[1]  = '{2'b00, 32'h01000000, 1'b0, 24'h000000, 1};
    vt[2]  = '{2'b01, 32'hFFFFFFFE, 1'b1, 24'hFFFFFE, 1};
    vt[3]  = '{2'b01, 32'h00800000, 1'b0, 24'h000000, 1};
    vt[4]  = '{2'b10, 32'hFFFFF800, 1'b1, 24'h000800, 1};
    vt[5]  = '{2'b10, 32'h00000800, 1'b0, 24'h000000, 1};
    vt[6]  = '{2'b10, 32'h000007FF, 1'b1, 24'h0007FF, 1};
    vt[7]  = '{2'b10, 32'hFFFFF7FF, 1'b0, 24'h000000, 1};
    vt[8]  = '{2'b11, 32'h000000FF, 1'b1, 24'h0000FF, 1};
    vt[9]  = '{2'b11, 32'hFF000000, 1'b1, 24'h0004FF, 5};
    vt[10] = '{2'b11, 32'hF000000F, 1'b1, 24'h0002FF, 3};
    vt[11] = '{2'b11, 32'h00000101, 1'b0, 24'h000000, 16};
    vt[12] = '{2'b11, 32'h00000000, 1'b1, 24'h000000, 1};
    vt[13] = '{2'b11, 32'h000003FC, 1'b1, 24'h000FFF, 16};
    vt[14] = '{2'b11, 32'h80000000, 1'b1, 24'h000102, 2};

    reset = 1'b1; start = 1'b0; data_i = '0; mode_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1); check("rst_done", done, 0);
    check("rst_fits", fits, 0);   check("rst_imm", imm_o, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    foreach (vt[i]) begin
      do_enc(vt[i].m, vt[i].v, 1'b0, lat, f, im);
      check($sformatf("v%0d_lat", i), lat, vt[i].lat);
      check($sformatf("v%0d_fits", i), f, vt[i].f);
      check($sformatf("v%0d_imm", i), im, vt[i].im);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_w", i), done, 0);
      check($sformatf("v%0d_idle", i), ready, 1);
    end

    // start pulsed while busy is ignored, and not queued
    do_enc(2'b11, 32'hFF000000, 1'b1, lat, f, im);
    check("busy_lat", lat, 5); check("busy_fits", f, 1); check("busy_imm", im, 24'h0004FF);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("busy_noq_done", done, 0);
      check("busy_noq_imm", imm_o, 24'h0004FF);
    end

    // Reset in the middle of a search (previous result has fits=1)
    start = 1'b1; data_i = 32'h00000101; mode_i = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("mid_busy", ready, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", ready, 1); check("mid_rst_done", done, 0);
    check("mid_rst_fits", fits, 0);   check("mid_rst_imm", imm_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_enc(2'b11, 32'h000000FF, 1'b0, lat, f, im);
    check("post_rst_lat", lat, 1); check("post_rst_imm", im, 24'h0000FF);
    @(posedge clk); #1;

    // Random values over the single-cycle modes
    for (int i = 0; i < 10000; i++) begin
      m = 2'($urandom_range(0, 2));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: v = x;
        1: v = {{8{x[23]}}, x[23:0]};
        2: v = {{20{x[11]}}, x[11:0]};
        default: v = {{8{x[23]}}, x[23:0]} ^ (32'h1 << $urandom_range(0, 31));
      endcase
      s = $signed(v);
      case (m)
        2'b00:   rf = (v <= 32'h00FFFFFF);
        2'b01:   rf = (s >= -8388608) && (s <= 8388607);
        default: rf = (s >= -2048) && (s <= 2047);
      endcase
      do_enc(m, v, 1'b0, lat, f, im);
      check("rnd_done", 32'(lat > 0), 1);
      check("rnd_fits", f, rf);
      if (rf) check("rnd_rt", extend(m, im), v);
      else    check("rnd_imm0", im, 0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
